// File: rtl/wave_capture_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wave_capture_multi_pkg
// Purpose  : Shared trigger-mode codes, FSM state encodings and width helper
//            for the multi-channel wave capture block.
// Revision : 1.0 - initial release
// ============================================================================
package wave_capture_multi_pkg;

    localparam logic [1:0] TRIG_RISE = 2'd0;
    localparam logic [1:0] TRIG_FALL = 2'd1;
    localparam logic [1:0] TRIG_FREE = 2'd2;
    localparam logic [1:0] TRIG_AUTO = 2'd3;

    localparam logic [1:0] ST_ARMED  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    // A one-channel build still needs a 1-bit trigger select port.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wave_capture_multi_trigger.sv
`default_nettype none
// ============================================================================
// Module   : wave_capture_multi_trigger
// Purpose  : Trigger source mux, previous-sign register, zero-cross detect
//            and auto-mode timeout counter.
// Revision : 1.0 - initial release
// ============================================================================
module wave_capture_multi_trigger
    import wave_capture_multi_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           new_sample,
    input  logic [NUM_CH-1:0]              sample_msb,
    input  logic [1:0]                     trig_mode,
    input  logic [clog2_min1(NUM_CH)-1:0]  trig_ch,
    input  logic                           armed,
    input  logic                           cnt_clr,
    output logic                           trig_hit,
    output logic                           trig_forced
);

    localparam int c_ch_w  = clog2_min1(NUM_CH);
    localparam int c_cnt_w = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(AUTO_TIMEOUT - 1);

    logic [1:0]         r_mode;
    logic [c_ch_w-1:0]  r_ch;
    logic               r_prev;
    logic [c_cnt_w-1:0] r_cnt;

    logic [1:0]         w_mode;
    logic [c_ch_w-1:0]  w_ch;
    logic               w_cur;
    logic               w_rise;
    logic               w_fall;
    logic               w_hit;

    // Selection is live while armed and frozen for the rest of a capture.
    assign w_mode = armed ? trig_mode : r_mode;
    assign w_ch   = armed ? trig_ch   : r_ch;

    // Out-of-range selects match no lane and fall back to channel 0.
    always_comb begin
        w_cur = sample_msb[0];
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == c_ch_w'(i)) begin
                w_cur = sample_msb[i];
            end
        end
    end

    assign w_rise = r_prev & ~w_cur;
    assign w_fall = ~r_prev & w_cur;

    always_comb begin
        w_hit = 1'b0;
        case (w_mode)
            TRIG_RISE: w_hit = w_rise;
            TRIG_FALL: w_hit = w_fall;
            TRIG_FREE: w_hit = 1'b1;
            default:   w_hit = w_rise | (r_cnt == c_cnt_max);
        endcase
    end

    assign trig_hit    = armed & new_sample & w_hit;
    assign trig_forced = (w_mode == TRIG_AUTO) & ~w_rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode <= TRIG_RISE;
            r_ch   <= '0;
            r_prev <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (armed) begin
                r_mode <= trig_mode;
                r_ch   <= trig_ch;
            end
            if (new_sample) begin
                r_prev <= w_cur;
            end
            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (armed && new_sample && !w_hit &&
                         (w_mode == TRIG_AUTO) && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wave_capture_multi.sv
`default_nettype none
// ============================================================================
// Module   : wave_capture_multi
// Purpose  : Triggered multi-channel capture into a ping-pong sample RAM.
// Revision : 1.0 - initial release
// ============================================================================
module wave_capture_multi
    import wave_capture_multi_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int SAMPLE_W     = 16,
    parameter int DISP_W       = 8,
    parameter int DEPTH_LOG2   = 8,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           new_sample,
    input  logic [NUM_CH*SAMPLE_W-1:0]     sample,
    input  logic [1:0]                     trig_mode,
    input  logic [clog2_min1(NUM_CH)-1:0]  trig_ch,
    input  logic                           wave_display_idle,
    output logic                           write_enable,
    output logic [DEPTH_LOG2:0]            write_address,
    output logic [NUM_CH*DISP_W-1:0]       write_sample,
    output logic                           read_index,
    output logic                           capturing,
    output logic                           forced_trig
);

    logic [1:0]               r_state;
    logic [DEPTH_LOG2-1:0]    r_index;
    logic                     r_read_index;
    logic                     r_we;
    logic [DEPTH_LOG2:0]      r_addr;
    logic [NUM_CH*DISP_W-1:0] r_data;
    logic                     r_forced;

    logic [NUM_CH-1:0]        w_msb;
    logic [NUM_CH*DISP_W-1:0] w_conv;
    logic                     w_trig_hit;
    logic                     w_trig_forced;
    logic                     w_unused_lsbs;

    // Two's complement to offset binary: keep the top DISP_W bits, flip the sign.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        assign w_msb[c] = sample[c*SAMPLE_W + SAMPLE_W - 1];
        assign w_conv[c*DISP_W +: DISP_W] =
            {~sample[c*SAMPLE_W + SAMPLE_W - 1],
              sample[c*SAMPLE_W + SAMPLE_W - 2 -: DISP_W - 1]};
    end

    assign w_unused_lsbs = ^sample;

    wave_capture_multi_trigger #(
        .NUM_CH       (NUM_CH),
        .AUTO_TIMEOUT (AUTO_TIMEOUT)
    ) u_trigger (
        .clk         (clk),
        .reset       (reset),
        .new_sample  (new_sample),
        .sample_msb  (w_msb),
        .trig_mode   (trig_mode),
        .trig_ch     (trig_ch),
        .armed       (r_state == ST_ARMED),
        .cnt_clr     ((r_state == ST_WAIT) && wave_display_idle),
        .trig_hit    (w_trig_hit),
        .trig_forced (w_trig_forced)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_ARMED;
            r_index      <= '0;
            r_read_index <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_forced     <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_ARMED: begin
                    if (w_trig_hit) begin
                        r_we     <= 1'b1;
                        r_addr   <= {~r_read_index, {DEPTH_LOG2{1'b0}}};
                        r_data   <= w_conv;
                        r_index  <= DEPTH_LOG2'(1);
                        r_forced <= w_trig_forced;
                        r_state  <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (new_sample) begin
                        r_we    <= 1'b1;
                        r_addr  <= {~r_read_index, r_index};
                        r_data  <= w_conv;
                        r_index <= r_index + 1'b1;
                        if (r_index == {DEPTH_LOG2{1'b1}}) begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Hand the filled half to the display only between its reads.
                    if (wave_display_idle) begin
                        r_read_index <= ~r_read_index;
                        r_state      <= ST_ARMED;
                    end
                end
                default: r_state <= ST_ARMED;
            endcase
        end
    end

    assign write_enable  = r_we;
    assign write_address = r_addr;
    assign write_sample  = r_data;
    assign read_index    = r_read_index;
    assign capturing     = (r_state == ST_ACTIVE);
    assign forced_trig   = r_forced;

endmodule
`default_nettype wire
